// File: rtl/morph_pkg.sv
// Shared encodings for the binary morphology filter: frame modes, per-stage
// ops, the stored pixel record and the mode-to-stage-op mapping.
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_BYP   = 2'b00,
        MODE_ERODE = 2'b01,
        MODE_OPEN  = 2'b10,
        MODE_CLOSE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OP_PASS   = 2'b00,
        OP_ERODE  = 2'b01,
        OP_DILATE = 2'b10
    } op_e;

    typedef struct packed {
        op_e op1;
        op_e op2;
    } op_pair_t;

    typedef struct packed {
        logic mask;
        logic de;
    } pix_t;

    function automatic op_pair_t mode_ops(input mode_e mode);
        op_pair_t ops;
        case (mode)
            MODE_ERODE: ops = '{op1: OP_ERODE,  op2: OP_PASS};
            MODE_OPEN:  ops = '{op1: OP_ERODE,  op2: OP_DILATE};
            MODE_CLOSE: ops = '{op1: OP_DILATE, op2: OP_ERODE};
            default:    ops = '{op1: OP_PASS,   op2: OP_PASS};
        endcase
        return ops;
    endfunction

endpackage

// File: rtl/morph_filter3x3_if.sv
// Pixel-stream bus of the morphology filter: mask plus video timing in,
// filtered mask plus delayed timing out, and the mode select/report pair.
interface morph_filter3x3_if;
    logic [1:0] mode;
    logic       mask;
    logic       in_de;
    logic       in_vsync;
    logic       in_hsync;
    logic       filtered;
    logic       out_de;
    logic       out_vsync;
    logic       out_hsync;
    logic [1:0] active_mode;

    modport master (
        output mode, mask, in_de, in_vsync, in_hsync,
        input  filtered, out_de, out_vsync, out_hsync, active_mode
    );

    modport slave (
        input  mode, mask, in_de, in_vsync, in_hsync,
        output filtered, out_de, out_vsync, out_hsync, active_mode
    );
endinterface

// File: rtl/morph_stage3x3.sv
// One 3x3 binary morphology stage: two line buffers feeding a 3x3 window,
// taps outside the active area count as neutral, op latched at each frame start.
module morph_stage3x3
    import morph_pkg::*;
#(
    parameter int H_SIZE = 83
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  op_e  op,
    input  logic in_mask,
    input  logic in_de,
    input  logic in_vsync,
    input  logic in_hsync,
    output logic out_mask,
    output logic out_de,
    output logic out_vsync,
    output logic out_hsync
);
    pix_t       lb0 [H_SIZE];
    pix_t       lb1 [H_SIZE];
    pix_t       row2 [2];
    logic [1:0] sync_dl [H_SIZE+1];
    logic       vs_prev;
    op_e        op_q;
    pix_t       cur;
    pix_t       win [9];
    logic       and_acc;
    logic       or_acc;
    logic       result;

    assign cur = '{mask: in_mask, de: in_de};

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        and_acc = 1'b1;
        or_acc  = 1'b0;
        result  = 1'b0;
        // Row 0 is the incoming line, row 1 holds the centre (delay H_SIZE+1), row 2 the oldest line.
        win[0] = cur;
        win[1] = lb0[0];
        win[2] = lb0[1];
        win[3] = lb0[H_SIZE-1];
        win[4] = lb1[0];
        win[5] = lb1[1];
        win[6] = lb1[H_SIZE-1];
        win[7] = row2[0];
        win[8] = row2[1];
        for (int k = 0; k < 9; k++) begin
            and_acc = and_acc & (win[k].mask | ~win[k].de);
            or_acc  = or_acc  | (win[k].mask &  win[k].de);
        end
        case (op_q)
            OP_ERODE:  result = and_acc;
            OP_DILATE: result = or_acc;
            default:   result = lb1[0].mask;
        endcase
        result = result & lb1[0].de;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the line buffers are reset as well, so a mid-frame reset never replays stale mask data.
            for (int i = 0; i < H_SIZE; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            for (int i = 0; i <= H_SIZE; i++) sync_dl[i] <= '0;
            row2[0]   <= '0;
            row2[1]   <= '0;
            vs_prev   <= 1'b0;
            op_q      <= OP_PASS;
            out_mask  <= 1'b0;
            out_de    <= 1'b0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
        end else if (ce) begin
            // NOTE: non-blocking throughout, so each shift stage takes its neighbour's pre-edge value.
            lb0[0] <= cur;
            for (int i = 1; i < H_SIZE; i++) lb0[i] <= lb0[i-1];
            lb1[0] <= lb0[H_SIZE-1];
            for (int i = 1; i < H_SIZE; i++) lb1[i] <= lb1[i-1];
            row2[0] <= lb1[H_SIZE-1];
            row2[1] <= row2[0];
            sync_dl[0] <= {in_vsync, in_hsync};
            for (int i = 1; i <= H_SIZE; i++) sync_dl[i] <= sync_dl[i-1];
            vs_prev <= in_vsync;
            if (in_vsync && !vs_prev) op_q <= op;
            out_mask               <= result;
            out_de                 <= lb1[0].de;
            {out_vsync, out_hsync} <= sync_dl[H_SIZE];
        end
    end

endmodule

// File: rtl/morph_filter3x3.sv
// Per-frame configurable binary morphology filter: two cascaded 3x3 stages
// (bypass / erode / open / close) with the frame mode carried alongside the video.
module morph_filter3x3
    import morph_pkg::*;
#(
    parameter int H_SIZE = 83
) (
    input logic              clk,
    input logic              rst,
    input logic              ce,
    morph_filter3x3_if.slave bus
);
    mode_e    mode_in;
    mode_e    mode1_q;
    mode_e    mode2_q;
    mode_e    active_q;
    op_pair_t ops_in;
    op_pair_t ops_frame;
    logic     in_vs_prev;
    logic     s1_vs_prev;
    logic     out_vs_prev;
    logic     s1_mask;
    logic     s1_de;
    logic     s1_vsync;
    logic     s1_hsync;
    logic     unused_ops;

    assign mode_in    = mode_e'(bus.mode);
    assign ops_in     = mode_ops(mode_in);
    assign ops_frame  = mode_ops(mode1_q);
    assign unused_ops = ^{ops_in.op2, ops_frame.op1};

    morph_stage3x3 #(.H_SIZE(H_SIZE)) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .op        (ops_in.op1),
        .in_mask   (bus.mask),
        .in_de     (bus.in_de),
        .in_vsync  (bus.in_vsync),
        .in_hsync  (bus.in_hsync),
        .out_mask  (s1_mask),
        .out_de    (s1_de),
        .out_vsync (s1_vsync),
        .out_hsync (s1_hsync)
    );

    // Stage 2 latches its op from the frame mode on its own, later, vsync edge.
    morph_stage3x3 #(.H_SIZE(H_SIZE)) u_stage2 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .op        (ops_frame.op2),
        .in_mask   (s1_mask),
        .in_de     (s1_de),
        .in_vsync  (s1_vsync),
        .in_hsync  (s1_hsync),
        .out_mask  (bus.filtered),
        .out_de    (bus.out_de),
        .out_vsync (bus.out_vsync),
        .out_hsync (bus.out_hsync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_vs_prev  <= 1'b0;
            s1_vs_prev  <= 1'b0;
            out_vs_prev <= 1'b0;
            mode1_q     <= MODE_BYP;
            mode2_q     <= MODE_BYP;
            active_q    <= MODE_BYP;
        end else if (ce) begin
            in_vs_prev  <= bus.in_vsync;
            s1_vs_prev  <= s1_vsync;
            out_vs_prev <= bus.out_vsync;
            if (bus.in_vsync && !in_vs_prev) mode1_q  <= mode_in;
            if (s1_vsync && !s1_vs_prev)     mode2_q  <= mode1_q;
            if (bus.out_vsync && !out_vs_prev) active_q <= mode2_q;
        end
    end

    // Show the new mode in the very cycle the delayed vsync rises.
    assign bus.active_mode = (bus.out_vsync && !out_vs_prev) ? mode2_q : active_q;

endmodule

// File: tb/tb_morph_filter3x3.sv
// Directed bench for morph_filter3x3 with H_SIZE=8: 5x5 active frames, hand-computed
// expected masks, a pixel-accurate expected stream delayed by 2*H_SIZE+4 ce cycles.
module tb_morph_filter3x3;
    localparam int H     = 8;
    localparam int LINES = 10;
    localparam int FRAME = H * LINES;
    localparam int LAT   = 2 * H + 4;

    localparam logic [24:0] BIT12     = 25'h0001000;
    localparam logic [24:0] BLOCK     = 25'h00739C0;
    localparam logic [24:0] RING      = 25'h00729C0;
    localparam logic [24:0] ISO_BLOCK = 25'h00739D0;
    localparam logic [24:0] ALL       = 25'h1FFFFFF;
    localparam logic [24:0] TOP_ROW   = 25'h000001F;

    typedef struct packed {
        bit         care;
        logic       filt;
        logic       de;
        logic       vs;
        logic       hs;
        logic [1:0] am;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [24:0] img;
        logic [24:0] expv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    morph_filter3x3_if bus ();

    morph_filter3x3 #(.H_SIZE(H)) dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   frame_no     = 0;
    exp_t q[$];
    exp_t last_exp;
    vec_t vecs [8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %02h, expected %02h (filt,de,vs,hs,mode)", name, act, expv);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.filtered, bus.out_de, bus.out_vsync, bus.out_hsync, bus.active_mode};
    endfunction

    // The pipeline holds LAT-1 zero pixels right after reset.
    task automatic prefill();
        exp_t z;
        z      = '0;
        z.care = 1'b1;
        q.delete();
        repeat (LAT - 1) q.push_back(z);
        last_exp = z;
    endtask

    task automatic compare_out(input exp_t e, input string where);
        if (e.care) check(where, {2'b00, outs()}, {2'b00, e.filt, e.de, e.vs, e.hs, e.am});
    endtask

    task automatic step(input logic m, input logic de, input logic vs, input logic hs,
                        input exp_t e, input bit rand_ce, input string where);
        int         idle;
        logic [3:0] junk;
        idle = rand_ce ? $urandom_range(0, 2) : 0;
        repeat (idle) begin
            junk         = 4'($urandom);
            ce           = 1'b0;
            bus.mask     = junk[0];
            bus.in_de    = junk[1];
            bus.in_vsync = junk[2];
            bus.in_hsync = junk[3];
            @(posedge clk);
            #1;
            compare_out(last_exp, {where, " hold"});
        end
        ce           = 1'b1;
        bus.mask     = m;
        bus.in_de    = de;
        bus.in_vsync = vs;
        bus.in_hsync = hs;
        q.push_back(e);
        @(posedge clk);
        #1;
        last_exp = q.pop_front();
        compare_out(last_exp, where);
    endtask

    task automatic pulse_reset(input string where);
        rst = 1'b0;
        #1;
        check({where, " in reset"}, {2'b00, outs()}, 8'h00);
        ce = 1'b1;
        @(posedge clk);
        #1;
        check({where, " reset held"}, {2'b00, outs()}, 8'h00);
        rst = 1'b1;
        prefill();
    endtask

    // Raster: line 0 vsync, lines 3..7 active (cols 0..4), hsync on cols 5..6.
    task automatic send_frame(input logic [1:0] fmode, input logic [24:0] img, input logic [24:0] expv,
                              input bit care, input bit rand_ce,
                              input int switch_at, input logic [1:0] switch_mode, input int rst_at);
        bit post_rst;
        post_rst = 1'b0;
        for (int n = 0; n < FRAME; n++) begin
            int   line;
            int   col;
            int   idx;
            logic de;
            logic m;
            logic em;
            exp_t e;
            line = n / H;
            col  = n % H;
            de   = (line >= 3 && line < 8 && col < 5);
            idx  = (line - 3) * 5 + col;
            m    = 1'b0;
            em   = 1'b0;
            if (de) begin
                m  = img[idx];
                em = expv[idx];
            end
            if (n == 0) bus.mode = fmode;
            if (n == switch_at) bus.mode = switch_mode;
            if (n == rst_at) begin
                pulse_reset($sformatf("frame%0d px%0d", frame_no, n));
                post_rst = 1'b1;
            end
            e      = '0;
            e.care = care && !post_rst;
            e.filt = em;
            e.de   = de;
            e.vs   = (line == 0);
            e.hs   = (col >= 5 && col < 7);
            e.am   = fmode;
            step(m, de, e.vs, e.hs, e, rand_ce, $sformatf("frame%0d px%0d", frame_no, n));
        end
        frame_no++;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Hand-computed 5x5 results; bit index = row*5 + col.
        vecs[0] = '{2'b00, BIT12,     BIT12};
        vecs[1] = '{2'b01, BLOCK,     BIT12};
        vecs[2] = '{2'b01, ALL,       ALL};
        vecs[3] = '{2'b10, ISO_BLOCK, BLOCK};
        vecs[4] = '{2'b11, RING,      ALL};
        vecs[5] = '{2'b11, BIT12,     BIT12};
        vecs[6] = '{2'b10, ALL,       ALL};
        vecs[7] = '{2'b01, TOP_ROW,   25'h0};

        bus.mode     = 2'b00;
        bus.mask     = 1'b0;
        bus.in_de    = 1'b0;
        bus.in_vsync = 1'b0;
        bus.in_hsync = 1'b0;
        #1;
        pulse_reset("initial");

        for (int v = 0; v < 8; v++)
            send_frame(vecs[v].mode, vecs[v].img, vecs[v].expv, 1'b1, 1'b0, -1, 2'b00, -1);

        // Mid-frame switch 00 -> 10: this frame stays bypassed, the next one is opened.
        send_frame(2'b00, ISO_BLOCK, ISO_BLOCK, 1'b1, 1'b0, 40, 2'b10, -1);
        send_frame(2'b10, ISO_BLOCK, BLOCK,     1'b1, 1'b0, -1, 2'b00, -1);

        // Random ce gaps must not change the result.
        send_frame(2'b01, BLOCK, BIT12, 1'b1, 1'b1, -1, 2'b00, -1);
        send_frame(2'b11, RING,  ALL,   1'b1, 1'b1, -1, 2'b00, -1);

        // Reset mid-frame; output is only required correct from the second vsync on.
        send_frame(2'b10, ISO_BLOCK, BLOCK, 1'b1, 1'b1, -1, 2'b00, 35);
        send_frame(2'b10, ISO_BLOCK, BLOCK, 1'b0, 1'b1, -1, 2'b00, -1);
        send_frame(2'b11, RING,      ALL,   1'b1, 1'b1, -1, 2'b00, -1);
        send_frame(2'b01, ALL,       ALL,   1'b1, 1'b0, -1, 2'b00, -1);

        // Trailing empty frame flushes the last real frame through the pipeline.
        send_frame(2'b00, 25'h0, 25'h0, 1'b1, 1'b0, -1, 2'b00, -1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/morph_filter3x3.md
# morph_filter3x3

Configurable binary morphological filter for the skin-colour segmentation path. It takes the 1-bit skin mask together with its video timing (`de`/`vsync`/`hsync`) and performs one of four operations on it: bypass, erosion, opening or closing. The operation is chosen per frame. The block replaces fixed erode→dilate chains, forwards `H_SIZE` correctly, honours `ce`, and treats pixels outside the active area as neutral. It sits between the skin classifier and the centroid/bounding-box logic.

## Interface
- `H_SIZE`, default 83: total line period in clock-enabled cycles, including horizontal blanking. Range 4..1023.
- `clk`  input  1  pixel clock
- `rst`  input  1  asynchronous, active-low reset
- `ce`  input  1  clock enable; the whole pipeline advances only when `ce`=1
- `mode`  input  2  operation select: 00 bypass, 01 erode, 10 open (erode→dilate), 11 close (dilate→erode)
- `mask`  input  1  input skin mask bit, 1 = skin
- `in_de`, `in_vsync`, `in_hsync`  input  1 each  timing aligned with `mask`
- `filtered`  output  1  result mask bit
- `out_de`, `out_vsync`, `out_hsync`  output  1 each  timing aligned with `filtered`
- `active_mode`  output  2  mode currently applied at the output

## Operation
- The block is two cascaded instances of `morph_stage3x3`. Each stage has an op select: ERODE (AND of the 3×3 window), DILATE (OR of the 3×3 window) or PASS (window centre).
- Per-mode stage ops (stage1/stage2):
  - bypass: PASS/PASS
  - erode: ERODE/PASS
  - open: ERODE/DILATE
  - close: DILATE/ERODE
- Mode latching:
  - Stage1 samples the op derived from `mode` on the rising edge of its own `in_vsync` (detected on `ce` cycles). It holds that op for the whole frame.
  - Stage2 receives stage1's decision through a 2-bit mode register. That register is delayed with the pipeline and latched on stage2's own `vsync` rising edge, so both stages switch on the same frame boundary.
  - A `mode` change in mid-frame has no effect until the next `vsync` rising edge.
- Each stage has two line buffers of depth `H_SIZE` plus a 3×3 shift window.
  - Every buffer entry stores 2 bits: mask and de.
  - All storage shifts on every `ce` cycle, including blanking.
- Border rule: a window tap whose stored de=0 counts as neutral, meaning 1 for ERODE and 0 for DILATE. Active-area edges therefore do not erode, and blanking never dilates into the image.
- Output gating: `filtered` is forced to 0 when `out_de`=0.
- Timing signals `de`/`vsync`/`hsync` are delayed by exactly the mask latency. Their polarity is unchanged.
- Reset (`rst`=0, asynchronous) clears:
  - all line buffers, windows and delay lines to 0
  - the mode registers to bypass
  - every output to 0, including `active_mode`=00
- Reset is asynchronous and may occur mid-frame. Output resumes correctly after the first complete frame, that is, after a `vsync` rising edge has passed through both stages.

## Timing
- Latency per stage: `H_SIZE`+2 `ce` cycles (centre tap plus output register).
- Total latency from `mask` to `filtered`: 2·`H_SIZE`+4 `ce` cycles, for all modes including bypass.
- When `ce`=0, all state holds and the outputs are stable.
- `active_mode` changes in the same cycle that the delayed `out_vsync` rises.
- There is no backpressure. The input is a continuous raster.

## Structure
- Package `morph_pkg` holds:
  - mode encodings `MODE_BYP`/`MODE_ERODE`/`MODE_OPEN`/`MODE_CLOSE`
  - stage op encodings `OP_PASS`/`OP_ERODE`/`OP_DILATE`
  - a function mapping mode to the (op1, op2) pair
- Sub-module `morph_stage3x3`:
  - parameter `H_SIZE`
  - ports: `clk`, `rst`, `ce`, `op`, mask/de/vsync/hsync in, the same four signals out
  - contains the line buffers, the window, the neutral-tap logic and the vsync-edge op latch
- The top level holds two stage instances plus the stage-to-stage mode delay register.

## Test plan
All scenarios use `H_SIZE`=8, with 5 active pixels per line and 5 active lines per frame.
- Bypass, single 1 at (2,2): `filtered` reproduces the input exactly, delayed 20 `ce` cycles.
- Erode, 3×3 block of 1s centred at (2,2): the output contains only (2,2)=1. Erode with an all-ones frame: the output is all ones, including the edges (neutral border).
- Open, isolated 1 at (0,4) plus a 3×3 block at (2,2): the isolated pixel is removed and the 3×3 block is restored intact.
- Close, 3×3 ring of 1s with a centre hole at (2,2): the hole is filled. Blanking columns stay 0.
- `mode` switched from 00 to 10 in mid-frame: the current frame stays bypassed, the next frame is opened, and `active_mode` changes to 10 exactly at the delayed `out_vsync` edge.
- `ce` toggled 1-0-1 at random, plus `rst` pulsed low mid-frame: with `ce` gating, the output matches the `ce`=1 golden model. During reset all outputs are 0, and output is correct from the second `vsync` onward.
